// File: rtl/quad_mask_generator.sv
// quad_mask_generator
//   Raster-order binary pixel source for an H_RES x V_RES frame. Each beat carries
//   one pixel: 1 when the pixel lies inside or on the quadrilateral UL->UR->DR->DL.
//   The four edge functions are built with multiplies once in SETUP, then stepped
//   by adds/subtracts while streaming.
//
// Optional feature: define QUAD_MASK_GENERATOR_COUNT_EN to add o_inside_count, the
//   number of accepted beats with o_data=1 in the current frame.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_start              start pulse, honoured only while idle; latches corners
//   i_ul/ur/dl/dr_addr   corner addresses {row[19:10], col[9:0]}
//   i_ready              downstream accepts the current beat
//   o_valid              o_data/o_row/o_col hold a pixel
//   o_data, o_row, o_col pixel value and its coordinates
//   o_busy               high in SETUP and RUN
//   o_frame_done         one-cycle pulse after the last pixel is accepted
//   o_inside_count       (optional) inside-pixel count for the frame
module quad_mask_generator #(
    parameter int unsigned H_RES = 800,
    parameter int unsigned V_RES = 600,
    parameter int unsigned ACC_W = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [19:0] i_ul_addr,
    input  logic [19:0] i_ur_addr,
    input  logic [19:0] i_dl_addr,
    input  logic [19:0] i_dr_addr,
    input  logic        i_ready,
    output logic        o_valid,
    output logic        o_data,
    output logic [9:0]  o_row,
    output logic [9:0]  o_col,
    output logic        o_busy,
    output logic        o_frame_done
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
    ,
    output logic [18:0] o_inside_count
`endif
);

    localparam logic [9:0] LastCol = 10'(H_RES - 1);
    localparam logic [9:0] LastRow = 10'(V_RES - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StRun} state_e;

    state_e state_q, state_d;
    logic [19:0] ul_q, ul_d, ur_q, ur_d, dl_q, dl_d, dr_q, dr_d;
    // e_*: edge value at the current pixel; acc_*: edge value at column 0 of the row
    logic signed [ACC_W-1:0] e_q [4];
    logic signed [ACC_W-1:0] e_d [4];
    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic        valid_q, valid_d, data_q, data_d, busy_q, busy_d, done_q, done_d;
    logic [9:0]  row_q, row_d, col_q, col_d;
    logic        load_pix;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
    logic [18:0] count_q, count_d;
`endif

    // Edge endpoints and derived terms
    logic [9:0]              p0_r [4];
    logic [9:0]              p0_c [4];
    logic [9:0]              p1_r [4];
    logic [9:0]              p1_c [4];
    logic signed [10:0]      d_row [4];
    logic signed [10:0]      d_col [4];
    logic signed [ACC_W-1:0] d_row_w [4];
    logic signed [ACC_W-1:0] d_col_w [4];
    logic signed [ACC_W-1:0] e_init [4];

    always_comb begin
        p0_r[0] = ul_q[19:10]; p0_c[0] = ul_q[9:0]; p1_r[0] = ur_q[19:10]; p1_c[0] = ur_q[9:0];
        p0_r[1] = ur_q[19:10]; p0_c[1] = ur_q[9:0]; p1_r[1] = dr_q[19:10]; p1_c[1] = dr_q[9:0];
        p0_r[2] = dr_q[19:10]; p0_c[2] = dr_q[9:0]; p1_r[2] = dl_q[19:10]; p1_c[2] = dl_q[9:0];
        p0_r[3] = dl_q[19:10]; p0_c[3] = dl_q[9:0]; p1_r[3] = ul_q[19:10]; p1_c[3] = ul_q[9:0];
        for (int k = 0; k < 4; k++) begin
            d_row[k]   = $signed({1'b0, p1_r[k]}) - $signed({1'b0, p0_r[k]});
            d_col[k]   = $signed({1'b0, p1_c[k]}) - $signed({1'b0, p0_c[k]});
            d_row_w[k] = {{(ACC_W - 11){d_row[k][10]}}, d_row[k]};
            d_col_w[k] = {{(ACC_W - 11){d_col[k][10]}}, d_col[k]};
            // E(0,0) = c0*(r1-r0) - r0*(c1-c0)
            e_init[k]  = $signed({{(ACC_W - 10){1'b0}}, p0_c[k]}) * d_row_w[k]
                       - $signed({{(ACC_W - 10){1'b0}}, p0_r[k]}) * d_col_w[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        ul_d     = ul_q;
        ur_d     = ur_q;
        dl_d     = dl_q;
        dr_d     = dr_q;
        e_d      = e_q;
        acc_d    = acc_q;
        valid_d  = valid_q;
        data_d   = data_q;
        row_d    = row_q;
        col_d    = col_q;
        done_d   = 1'b0;
        load_pix = 1'b0;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
        count_d  = count_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    ul_d    = i_ul_addr;
                    ur_d    = i_ur_addr;
                    dl_d    = i_dl_addr;
                    dr_d    = i_dr_addr;
                    state_d = StSetup;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
                    count_d = '0;
`endif
                end
            end
            StSetup: begin
                e_d      = e_init;
                acc_d    = e_init;
                row_d    = '0;
                col_d    = '0;
                valid_d  = 1'b1;
                load_pix = 1'b1;
                state_d  = StRun;
            end
            StRun: begin
                if (valid_q && i_ready) begin
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
                    if (data_q) count_d = count_q + 19'd1;
`endif
                    if (row_q == LastRow && col_q == LastCol) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (col_q == LastCol) begin
                        for (int k = 0; k < 4; k++) begin
                            acc_d[k] = acc_q[k] + d_col_w[k];
                            e_d[k]   = acc_q[k] + d_col_w[k];
                        end
                        row_d    = row_q + 10'd1;
                        col_d    = '0;
                        load_pix = 1'b1;
                    end else begin
                        for (int k = 0; k < 4; k++) e_d[k] = e_q[k] - d_row_w[k];
                        col_d    = col_q + 10'd1;
                        load_pix = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Inside when no edge value is negative
        if (load_pix) begin
            data_d = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (e_d[k][ACC_W-1]) data_d = 1'b0;
            end
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            ul_q    <= {10'd0, 10'd0};
            ur_q    <= {10'd0, LastCol};
            dl_q    <= {LastRow, 10'd0};
            dr_q    <= {LastRow, LastCol};
            for (int k = 0; k < 4; k++) begin
                e_q[k]   <= '0;
                acc_q[k] <= '0;
            end
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ul_q    <= ul_d;
            ur_q    <= ur_d;
            dl_q    <= dl_d;
            dr_q    <= dr_d;
            for (int k = 0; k < 4; k++) begin
                e_q[k]   <= e_d[k];
                acc_q[k] <= acc_d[k];
            end
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_row        = row_q;
    assign o_col        = col_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
    assign o_inside_count = count_q;
`endif

endmodule

// File: tb/tb_quad_mask_generator.sv
// Bench for quad_mask_generator on a reduced 48x32 frame. Expected beats come from a
// direct edge-function evaluation per pixel and are queued at each accepted start;
// a negedge monitor pops and compares every transferred beat.
module tb_quad_mask_generator;

    localparam int H = 48;
    localparam int V = 32;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_ready;
    logic [19:0] i_ul_addr, i_ur_addr, i_dl_addr, i_dr_addr;
    logic        o_valid, o_data, o_busy, o_frame_done;
    logic [9:0]  o_row, o_col;
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
    logic [18:0] o_inside_count;
`endif

    always #5 clk = ~clk;

    quad_mask_generator #(.H_RES(H), .V_RES(V), .ACC_W(24)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_ul_addr    (i_ul_addr),
        .i_ur_addr    (i_ur_addr),
        .i_dl_addr    (i_dl_addr),
        .i_dr_addr    (i_dr_addr),
        .i_ready      (i_ready),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_row        (o_row),
        .o_col        (o_col),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
        ,
        .o_inside_count (o_inside_count)
`endif
    );

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] c;
        logic       d;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    m_r[4];          // model corners in walk order UL, UR, DR, DL
    int    m_c[4];
    int    cur_ones_exp;
    bit    dut_map[V][H];
    int    dut_ones;
    int    beats;
    int    frames_done = 0;
    bit    expect_done = 0;
    bit    stall_prev = 0;
    beat_t stall_val;
    bit    rand_ready = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel is inside when every edge function of the closed walk is non-negative.
    function automatic bit model_inside(input int r, input int c);
        for (int k = 0; k < 4; k++) begin
            int k1 = (k + 1) % 4;
            int e  = (r - m_r[k]) * (m_c[k1] - m_c[k]) - (c - m_c[k]) * (m_r[k1] - m_r[k]);
            if (e < 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic push_frame();
        beat_t b;
        cur_ones_exp = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                b.r = 10'(r);
                b.c = 10'(c);
                b.d = model_inside(r, c);
                exp_q.push_back(b);
                cur_ones_exp += int'(b.d);
            end
        end
    endtask

    // Corners given as UL, UR, DR, DL (row, col)
    task automatic start_frame(input int ulr, input int ulc, input int urr, input int urc,
                               input int drr, input int drc, input int dlr, input int dlc);
        m_r[0] = ulr; m_c[0] = ulc; m_r[1] = urr; m_c[1] = urc;
        m_r[2] = drr; m_c[2] = drc; m_r[3] = dlr; m_c[3] = dlc;
        push_frame();
        for (int r = 0; r < V; r++) for (int c = 0; c < H; c++) dut_map[r][c] = 1'b0;
        dut_ones = 0;
        beats    = 0;
        @(posedge clk); #1;
        i_ul_addr = {10'(ulr), 10'(ulc)};
        i_ur_addr = {10'(urr), 10'(urc)};
        i_dr_addr = {10'(drr), 10'(drc)};
        i_dl_addr = {10'(dlr), 10'(dlc)};
        i_start   = 1'b1;
        @(posedge clk); #1;
        i_start   = 1'b0;
        // corners are free to change once latched
        i_ul_addr = 20'($urandom); i_ur_addr = 20'($urandom);
        i_dl_addr = 20'($urandom); i_dr_addr = 20'($urandom);
        check("setup_busy", 32'(o_busy), 1);
        check("setup_valid", 32'(o_valid), 0);
        @(posedge clk); #1;
        check("first_valid", 32'(o_valid), 1);
        check("first_pixel", {o_row, o_col}, 0);
    endtask

    task automatic wait_frame();
        int n  = 0;
        int f0 = frames_done;
        while (frames_done == f0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("frame_timeout", 32'(frames_done != f0), 1);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("ones_count", dut_ones, cur_ones_exp);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("beat_budget", 32'(beats >= target), 1);
    endtask

    task automatic spot(input string name, input int r, input int c, input bit exp);
        check(name, 32'(dut_map[r][c]), 32'(exp));
    endtask

    // Ready driver
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (!i_rst) begin
            if (expect_done || o_frame_done) begin
                check("frame_done", 32'(o_frame_done), 32'(expect_done));
                if (expect_done) check("busy_after_done", 32'(o_busy), 0);
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
                if (o_frame_done) check("inside_count", 32'(o_inside_count), cur_ones_exp);
`endif
                if (o_frame_done) frames_done++;
            end
            expect_done = 1'b0;
            if (stall_prev) check("stall_hold", {o_valid, o_row, o_col, o_data}, {1'b1, stall_val});
            stall_prev = 1'b0;
            if (o_valid) begin
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got row %0d col %0d, required none",
                                 o_row, o_col);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {o_row, o_col, o_data}, 32'(e));
                    end
                    if (int'(o_row) < V && int'(o_col) < H) dut_map[o_row][o_col] = o_data;
                    dut_ones += int'(o_data);
                    beats++;
                    if (int'(o_row) == V - 1 && int'(o_col) == H - 1) expect_done = 1'b1;
                end else begin
                    stall_prev = 1'b1;
                    stall_val  = '{r: o_row, c: o_col, d: o_data};
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_start = 1'b0;
        i_ul_addr = '0; i_ur_addr = '0; i_dl_addr = '0; i_dr_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_rowcol", {o_row, o_col}, 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_frame_done), 0);

        // Full frame, always ready
        start_frame(0, 0, 0, H - 1, V - 1, H - 1, V - 1, 0);
        wait_frame();
        check("full_ones", dut_ones, H * V);

        // Square 20x20, always ready
        start_frame(8, 10, 8, 29, 27, 29, 27, 10);
        wait_frame();
        check("square_ones", dut_ones, 400);
        spot("sq_ul_in", 8, 10, 1);
        spot("sq_above_out", 7, 10, 0);
        spot("sq_dr_in", 27, 29, 1);
        spot("sq_below_out", 28, 29, 0);
        spot("sq_left_out", 15, 9, 0);
        spot("sq_right_out", 15, 30, 0);

        // Same square with stalls
        rand_ready = 1'b1;
        start_frame(8, 10, 8, 29, 27, 29, 27, 10);
        wait_frame();
        check("square_stall_ones", dut_ones, 400);

        // Diamond
        start_frame(0, 24, 15, 47, 31, 24, 15, 0);
        wait_frame();
        spot("dia_top", 0, 24, 1);
        spot("dia_centre", 15, 24, 1);
        spot("dia_corner_ul", 0, 0, 0);
        spot("dia_corner_dr", 31, 47, 0);
        spot("dia_left_tip", 15, 0, 1);

        // Random quads, including degenerate and non-convex shapes
        for (int i = 0; i < 4; i++) begin
            start_frame($urandom_range(0, V - 1), $urandom_range(0, H - 1),
                        $urandom_range(0, V - 1), $urandom_range(0, H - 1),
                        $urandom_range(0, V - 1), $urandom_range(0, H - 1),
                        $urandom_range(0, V - 1), $urandom_range(0, H - 1));
            wait_frame();
        end

        // Start pulse mid-frame must be ignored
        start_frame(8, 10, 8, 29, 27, 29, 27, 10);
        wait_beats(300);
        @(posedge clk); #1;
        i_ul_addr = {10'd0, 10'd0};
        i_ur_addr = {10'd0, 10'(H - 1)};
        i_dr_addr = {10'(V - 1), 10'(H - 1)};
        i_dl_addr = {10'(V - 1), 10'd0};
        i_start   = 1'b1;
        @(posedge clk); #1;
        i_start   = 1'b0;
        check("ignored_start_busy", 32'(o_busy), 1);
        wait_frame();
        check("ignored_start_ones", dut_ones, 400);

        // Reset mid-frame abandons it; a new start restarts at (0,0)
        start_frame(0, 0, 0, H - 1, V - 1, H - 1, V - 1, 0);
        wait_beats(500);
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        exp_q.delete();
        stall_prev  = 1'b0;
        expect_done = 1'b0;
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_busy", 32'(o_busy), 0);
        check("midrst_done", 32'(o_frame_done), 0);
        check("midrst_rowcol", {o_row, o_col}, 0);
`ifdef QUAD_MASK_GENERATOR_COUNT_EN
        check("midrst_count", 32'(o_inside_count), 0);
`endif
        rand_ready = 1'b0;
        start_frame(8, 10, 8, 29, 27, 29, 27, 10);
        wait_frame();
        check("restart_ones", dut_ones, 400);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
